// File: rtl/bufferm_pkg.sv
// Shared types and default widths for the loadable per-PE constant buffer.
package bufferm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FULL = 2'd2
  } state_e;

  localparam int unsigned ADDR_LEN_DEF = 10;
  localparam int unsigned DATA_LEN_DEF = 16;

endpackage

// File: rtl/bufferm_mem.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
module bufferm_mem
  import bufferm_pkg::*;
#(
  parameter int unsigned ADDR_LEN = ADDR_LEN_DEF,
  parameter int unsigned DATA_LEN = DATA_LEN_DEF
) (
  input  logic                clk,
  input  logic                we,
  input  logic [ADDR_LEN-1:0] waddr,
  input  logic [DATA_LEN-1:0] wdata,
  input  logic                re,
  input  logic [ADDR_LEN-1:0] raddr,
  output logic [DATA_LEN-1:0] rdata
);

  logic [DATA_LEN-1:0] mem_q [2**ADDR_LEN];
  logic [DATA_LEN-1:0] rdata_q;

  // No reset on storage or read register so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/bufferm_loadable.sv
// Per-PE loadable constant buffer: a valid/ready load stream fills the RAM,
// registered reads return DEFAULT_VAL for addresses not yet covered by word_count.
module bufferm_loadable
  import bufferm_pkg::*;
#(
  parameter int unsigned         ADDR_LEN    = ADDR_LEN_DEF,
  parameter int unsigned         DATA_LEN    = DATA_LEN_DEF,
  parameter logic [DATA_LEN-1:0] DEFAULT_VAL = '0,
  parameter int                  PE_ID       = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ld_start,
  input  logic                ld_valid,
  output logic                ld_ready,
  input  logic [DATA_LEN-1:0] ld_data,
  input  logic                ld_last,
  output logic                ld_done,
  output logic                ld_overflow,
  output logic [ADDR_LEN:0]   word_count,
  input  logic                rd_en,
  input  logic [ADDR_LEN-1:0] rd_addr,
  output logic                rd_valid,
  output logic [DATA_LEN-1:0] data_out
);

  localparam logic [ADDR_LEN:0] WC_FULL = {1'b1, {ADDR_LEN{1'b0}}};

  state_e              state_q, state_d;
  logic [ADDR_LEN:0]   wc_q, wc_d;
  logic                done_q, done_d;
  logic                ovf_q, ovf_d;
  logic                rd_valid_q;
  logic                in_range_q, in_range_d;
  logic                rd_seen_q, rd_seen_d;
  logic                ld_fire;
  logic [DATA_LEN-1:0] mem_rdata;

  // Debug-only instance tag, kept as a named net for netlist inspection.
  logic [31:0] unused_pe_id;
  assign unused_pe_id = 32'(PE_ID);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      wc_q       <= '0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      in_range_q <= 1'b0;
      rd_seen_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wc_q       <= wc_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      rd_valid_q <= rd_en;
      in_range_q <= in_range_d;
      rd_seen_q  <= rd_seen_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wc_d       = wc_q;
    done_d     = 1'b0;
    ovf_d      = ovf_q;
    // Range is captured against the pre-write count: a same-cycle write is not yet visible.
    in_range_d = rd_en ? ({1'b0, rd_addr} < wc_q) : in_range_q;
    rd_seen_d  = rd_seen_q | rd_en;
    if (ld_start) begin
      state_d = ST_LOAD;
      wc_d    = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_LOAD: begin
          if (ld_fire) begin
            wc_d = wc_q + (ADDR_LEN+1)'(1);
            if (ld_last) begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end else if (wc_d == WC_FULL) begin
              state_d = ST_FULL;
            end
          end
        end
        ST_FULL: begin
          if (ld_valid) begin
            ovf_d = 1'b1;
            if (ld_last) begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ld_ready = (state_q == ST_LOAD);
    ld_fire  = ld_ready && ld_valid && !ld_start;
    // Until the first read after reset, the unreset RAM register is masked to zero.
    if (!rd_seen_q)      data_out = '0;
    else if (in_range_q) data_out = mem_rdata;
    else                 data_out = DEFAULT_VAL;
  end

  assign ld_done     = done_q;
  assign ld_overflow = ovf_q;
  assign word_count  = wc_q;
  assign rd_valid    = rd_valid_q;

  bufferm_mem #(
    .ADDR_LEN (ADDR_LEN),
    .DATA_LEN (DATA_LEN)
  ) u_mem (
    .clk   (clk),
    .we    (ld_fire),
    .waddr (wc_q[ADDR_LEN-1:0]),
    .wdata (ld_data),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_bufferm_loadable.sv
// Self-checking bench for bufferm_loadable against a queue-based reference model.
module tb_bufferm_loadable;

  localparam int unsigned AW    = 2;
  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 4;
  localparam logic [15:0] DEF   = 16'hD0D0;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          ld_start = 1'b0, ld_valid = 1'b0, ld_last = 1'b0, rd_en = 1'b0;
  logic [DW-1:0] ld_data = '0;
  logic [AW-1:0] rd_addr = '0;
  logic          ld_ready, ld_done, ld_overflow, rd_valid;
  logic [AW:0]   word_count;
  logic [DW-1:0] data_out;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Reference model: loaded words in order, plus a loading flag and sticky flags.
  logic [15:0] words[$];
  bit          loading = 0;
  bit          m_ovf = 0, m_done = 0, m_rdv = 0;
  logic [15:0] m_dout = '0;

  always #5 clk = ~clk;

  bufferm_loadable #(
    .ADDR_LEN    (AW),
    .DATA_LEN    (DW),
    .DEFAULT_VAL (DEF),
    .PE_ID       (5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ld_start    (ld_start),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_data     (ld_data),
    .ld_last     (ld_last),
    .ld_done     (ld_done),
    .ld_overflow (ld_overflow),
    .word_count  (word_count),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_valid    (rd_valid),
    .data_out    (data_out)
  );

  function automatic logic [22:0] dut_vec();
    return {ld_ready, ld_done, ld_overflow, word_count, rd_valid, data_out};
  endfunction

  function automatic logic [22:0] model_vec();
    bit rdy;
    rdy = loading && (words.size() < DEPTH);
    return {rdy, m_done, m_ovf, 3'(words.size()), m_rdv, m_dout};
  endfunction

  function automatic void model_reset();
    words.delete();
    loading = 0; m_ovf = 0; m_done = 0; m_rdv = 0; m_dout = '0;
  endfunction

  function automatic void model_step(bit start, bit valid, logic [15:0] data, bit last,
                                     bit ren, int unsigned addr);
    m_rdv = ren;
    if (ren) m_dout = (addr < words.size()) ? words[addr] : DEF;
    m_done = 0;
    if (start) begin
      words.delete();
      m_ovf   = 0;
      loading = 1;
    end else if (loading && valid) begin
      if (words.size() < DEPTH) words.push_back(data);
      else m_ovf = 1;
      if (last) begin
        m_done  = 1;
        loading = 0;
      end
    end
  endfunction

  task automatic drive(bit start, bit valid, logic [15:0] data, bit last, bit ren, int unsigned addr);
    ld_start = start; ld_valid = valid; ld_data = data; ld_last = last;
    rd_en = ren; rd_addr = AW'(addr);
    model_step(start, valid, data, last, ren, addr);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (dut_vec() !== model_vec()) begin
      errors++; $display("FAIL reset_state got=%h exp=%h", dut_vec(), model_vec());
    end
    reset = 1'b1;
    drive(0, 0, 16'h0, 0, 1, 0);
    checks++;
    if (dut_vec() !== model_vec()) begin
      errors++; $display("FAIL reset_read got=%h exp=%h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_basic_load();
    logic [15:0] w[3];
    w[0] = 16'h0001; w[1] = 16'h00A5; w[2] = 16'hBEEF;
    drive(1, 0, 16'h0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      if (i < 3) drive(0, 1, w[i], i == 2, 0, 0);
      else       drive(0, 0, 16'h0, 0, 0, 0);
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL basic_load[%0d] got=%h exp=%h", i, dut_vec(), model_vec());
      end
    end
    for (int a = 0; a < 4; a++) begin
      drive(0, 0, 16'h0, 0, 1, a);
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL basic_read[%0d] got=%h exp=%h", a, dut_vec(), model_vec());
      end
    end
    drive(0, 0, 16'h0, 0, 0, 0);
    checks++;
    if (dut_vec() !== model_vec()) begin
      errors++; $display("FAIL basic_hold got=%h exp=%h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_full();
    drive(1, 0, 16'h0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      drive(0, 1, 16'(16'h1100 + i), 0, 0, 0);
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL full_offer[%0d] got=%h exp=%h", i, dut_vec(), model_vec());
      end
    end
    drive(0, 1, 16'h7777, 1, 0, 0);
    checks++;
    if (dut_vec() !== model_vec()) begin
      errors++; $display("FAIL full_last got=%h exp=%h", dut_vec(), model_vec());
    end
    for (int a = 0; a < 4; a++) begin
      drive(0, 0, 16'h0, 0, 1, a);
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL full_read[%0d] got=%h exp=%h", a, dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_restart();
    drive(1, 0, 16'h0, 0, 0, 0);
    drive(0, 1, 16'hAAAA, 0, 0, 0);
    drive(0, 1, 16'hBBBB, 0, 0, 0);
    drive(1, 1, 16'hCCCC, 0, 0, 0);
    checks++;
    if (dut_vec() !== model_vec()) begin
      errors++; $display("FAIL restart_clear got=%h exp=%h", dut_vec(), model_vec());
    end
    drive(0, 1, 16'h5A5A, 1, 0, 0);
    for (int a = 0; a < 2; a++) begin
      drive(0, 0, 16'h0, 0, 1, a);
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL restart_read[%0d] got=%h exp=%h", a, dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_collision();
    drive(1, 0, 16'h0, 0, 0, 0);
    drive(0, 1, 16'h1234, 0, 1, 0);
    checks++;
    if (dut_vec() !== model_vec()) begin
      errors++; $display("FAIL collide_same got=%h exp=%h", dut_vec(), model_vec());
    end
    drive(0, 0, 16'h0, 0, 1, 0);
    checks++;
    if (dut_vec() !== model_vec()) begin
      errors++; $display("FAIL collide_next got=%h exp=%h", dut_vec(), model_vec());
    end
    drive(0, 1, 16'h0FFF, 1, 0, 0);
  endtask

  task automatic test_async_reset();
    drive(1, 0, 16'h0, 0, 0, 0);
    drive(0, 1, 16'h2222, 0, 0, 0);
    drive(0, 1, 16'h3333, 0, 1, 1);
    ld_valid = 1'b1; ld_data = 16'h4444;
    #2 reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if (dut_vec() !== model_vec()) begin
      errors++; $display("FAIL async_reset got=%h exp=%h", dut_vec(), model_vec());
    end
    ld_valid = 1'b0; rd_en = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int a = 0; a < 2; a++) begin
      drive(0, 0, 16'h0, 0, 1, a);
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL async_read[%0d] got=%h exp=%h", a, dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_random();
    bit st, vl, ls, re;
    drive(1, 0, 16'h0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      st = ($urandom_range(0, 99) < 4);
      vl = ($urandom_range(0, 9) < 6);
      ls = ($urandom_range(0, 9) == 0);
      re = $urandom_range(0, 1);
      drive(st, vl, 16'($urandom), ls, re, $urandom_range(0, 3));
      if (!loading && $urandom_range(0, 3) == 0) drive(1, 0, 16'h0, 0, 0, 0);
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL random[%0d] got=%h exp=%h", i, dut_vec(), model_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_full();
    test_restart();
    test_collision();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bufferm_loadable.md
Name: bufferm_loadable

Overview:
- Per-PE constant/metadata buffer; next generation of the hard-coded per-peId constant ROM.
- Contents are streamed in at run time over a valid/ready load port instead of being fixed at elaboration.
- Reads are registered (1-cycle latency) and return a programmable default for unloaded addresses.
- One instance per PE, between the PE's instruction decoder (read side) and the PE's memory-interface feeder (load side).

Parameters:
- ADDR_LEN, 10, read/load address width; DEPTH = 2**ADDR_LEN entries.
- DATA_LEN, 16, word width.
- DEFAULT_VAL, 0, value returned for any address >= word_count.
- PE_ID, 0, instance identifier; carried for debug only, no functional effect.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- ld_start  in  1  one-cycle pulse; clears word_count and enters LOAD.
- ld_valid  in  1  load word present.
- ld_ready  out  1  buffer accepts load word.
- ld_data  in  DATA_LEN  load word.
- ld_last  in  1  qualifies the final load word (sampled with ld_valid && ld_ready).
- ld_done  out  1  one-cycle pulse after the final word is written.
- ld_overflow  out  1  sticky; a word was offered while the buffer was full.
- word_count  out  ADDR_LEN+1  number of valid entries.
- rd_en  in  1  read request.
- rd_addr  in  ADDR_LEN  read address.
- rd_valid  out  1  data_out valid (rd_en delayed one cycle).
- data_out  out  DATA_LEN  registered read data.

Behaviour:
- Reset (reset=0, async) sets:
  - state=IDLE, word_count=0, ld_ready=0, ld_done=0, ld_overflow=0, rd_valid=0, data_out=0.
  - Storage array is not reset; word_count gates its visibility.
- FSM states IDLE, LOAD, FULL:
  - IDLE: ld_ready=0. ld_start -> LOAD, word_count<=0, ld_overflow<=0.
  - LOAD: ld_ready=1.
    - Handshake (ld_valid&&ld_ready): mem[word_count]<=ld_data, word_count++.
    - If ld_last in the handshake cycle: ld_done pulses next cycle, -> IDLE.
    - Else if word_count reaches DEPTH: -> FULL.
  - FULL: ld_ready=0.
    - ld_valid in FULL sets ld_overflow (sticky) and the word is dropped.
    - ld_last&&ld_valid in FULL: ld_done pulses, -> IDLE.
  - ld_start in any state, including mid-LOAD, restarts: word_count<=0, ld_overflow<=0, -> LOAD. A handshake in the same cycle as ld_start is discarded.
- Read path:
  - On rd_en: data_out <= (rd_addr < word_count) ? mem[rd_addr] : DEFAULT_VAL, and rd_valid<=1 next cycle.
  - Without rd_en: rd_valid<=0 and data_out holds its previous value.
  - Reads are legal in every state.
- Same-cycle read and write to the same address: the read returns DEFAULT_VAL, because word_count has not yet covered that address (read-before-write). The following cycle returns the new word.
- Width rules:
  - word_count is ADDR_LEN+1 bits so DEPTH is representable.
  - Compare rd_addr zero-extended against word_count.
- word_count never exceeds DEPTH and never wraps.
- Reset asserted mid-load aborts immediately; previously loaded data is inaccessible until reloaded.

Decomposition:
- Shared package bufferm_pkg:
  - FSM state enum (IDLE/LOAD/FULL, 2-bit).
  - Default widths ADDR_LEN_DEF=10, DATA_LEN_DEF=16.
- One natural sub-module: bufferm_mem.
  - Simple dual-port synchronous RAM, one write port and one registered read port, inferable as block RAM.
  - The parent holds the FSM, word_count and the default-value mux. The mux uses a registered copy of (rd_addr < word_count) to align with RAM latency.

Test Plan:
1. Reset then read: reset low 3 cycles, release; rd_en, rd_addr=0 -> next cycle rd_valid=1, data_out=0 (DEFAULT_VAL), word_count=0, ld_ready=0.
2. Basic load/read:
   - Stimulus: ld_start; stream 0x0001, 0x00A5, 0xBEEF with ld_last on the third.
   - Required: ld_done pulses once, word_count=3.
   - Reads of addr 0,1,2,3 return 0x0001, 0x00A5, 0xBEEF, 0x0000, each 1 cycle after rd_en.
3. Backpressure and full (ADDR_LEN=2):
   - Stimulus: stream 6 words with no ld_last.
   - Required: after 4 handshakes ld_ready=0, state FULL, word_count=4, ld_overflow=1 on the 5th offer.
   - Then ld_last with ld_valid -> ld_done pulses, state IDLE.
4. Restart mid-load: load 2 words, pulse ld_start together with ld_valid -> that word is dropped, word_count=0, ld_overflow=0; reload 1 word -> addr 1 now reads DEFAULT_VAL.
5. Read/write collision: during LOAD, write 0x1234 to addr 0 while rd_en with rd_addr=0 in the same cycle -> data_out=0x0000; a re-read next cycle -> 0x1234.
6. Async reset mid-load: drop reset after 2 handshakes, asynchronously to clk -> all outputs zero immediately, word_count=0; subsequent reads of addr 0,1 return DEFAULT_VAL.
